// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: drives the data-memory req/gnt/rvalid bus and the register-file write port.
// Optional MISALIGN_TRAP_EN adds misalign/misalign_addr outputs and suppresses misaligned accesses.
module mem_wb_stage #(
   parameter int REQ_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   input  logic [4:0]  rd_in,
   input  logic [31:0] wdata_in,
   input  logic [31:0] alu_res_in,
   input  logic [31:0] csr_rdata_in,
   input  logic        rf_en_in,
   input  logic        mem_write_in,
   input  logic        is_load_in,
   input  logic        is_csr_in,
   input  logic        is_jal_in,
   input  logic        is_jalr_in,
   input  logic [2:0]  load_type_in,
   input  logic        load_unsigned_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        dmem_err,
   output logic        stall,
`ifdef MISALIGN_TRAP_EN
   output logic        misalign,
   output logic [31:0] misalign_addr,
`endif
   output logic        wb_en,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data
);

   localparam int CW = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t        state, state_nxt;
   logic [31:0]   load_reg;
   logic          aborted;
   logic [CW-1:0] cnt;

   logic          mem_op, misaligned, timed_out;
   logic          req_int, stall_int, err_int;
   logic [1:0]    size, lane;
   logic          is_byte, is_half, uns;
   logic [3:0]    be_int;
   logic [31:0]   st_data, shifted, load_ext;

   assign mem_op  = is_load_in | mem_write_in;
   assign size    = load_type_in[1:0];
   assign is_byte = (size == 2'b00);
   assign is_half = (size == 2'b01);
   // funct3[2] is the RV32 unsigned-load bit, so it is honoured alongside the explicit flag
   assign uns     = load_unsigned_in | load_type_in[2];

`ifdef MISALIGN_TRAP_EN
   assign misaligned = mem_op & ((is_half & alu_res_in[0]) | (size[1] & (|alu_res_in[1:0])));
`else
   assign misaligned = 1'b0;
`endif

   assign timed_out = (REQ_TIMEOUT > 0) && (cnt == CW'(REQ_TIMEOUT));

   // Address bits below the access size are ignored: H uses a[1] only, W uses none.
   assign lane = is_byte ? alu_res_in[1:0] : (is_half ? {alu_res_in[1], 1'b0} : 2'b00);

   always_comb begin
      be_int  = 4'b1111;
      st_data = wdata_in;
      if (is_byte) begin
         be_int  = 4'b0001 << lane;
         st_data = {4{wdata_in[7:0]}};
      end else if (is_half) begin
         be_int  = 4'b0011 << lane;
         st_data = {2{wdata_in[15:0]}};
      end
   end

   assign shifted = dmem_rdata >> {lane, 3'b000};

   always_comb begin
      load_ext = shifted;
      if (is_byte)
         load_ext = {{24{~uns & shifted[7]}}, shifted[7:0]};
      else if (is_half)
         load_ext = {{16{~uns & shifted[15]}}, shifted[15:0]};
   end

   always_comb begin
      state_nxt = state;
      req_int   = 1'b0;
      stall_int = 1'b0;
      err_int   = 1'b0;
      case (state)
         IDLE: begin
            if (mem_op && !misaligned) begin
               stall_int = 1'b1;
               if (timed_out) begin
                  err_int   = 1'b1;
                  state_nxt = DONE;
               end else begin
                  req_int = 1'b1;
                  if (dmem_gnt)
                     state_nxt = mem_write_in ? DONE : WAIT;
               end
            end
         end
         WAIT: begin
            stall_int = 1'b1;
            if (dmem_rvalid) begin
               state_nxt = DONE;
            end else if (timed_out) begin
               err_int   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         load_reg <= '0;
         aborted  <= 1'b0;
         cnt      <= '0;
      end else begin
         state   <= state_nxt;
         aborted <= err_int;
         if (state == WAIT && dmem_rvalid)
            load_reg <= load_ext;
         // Counts only while waiting on the bus; any handshake or abort restarts it.
         if ((REQ_TIMEOUT > 0) && !timed_out &&
             ((state == IDLE && req_int && !dmem_gnt) || (state == WAIT && !dmem_rvalid)))
            cnt <= cnt + CW'(1);
         else
            cnt <= '0;
      end
   end

   assign dmem_req   = req_int & ~rst;
   assign dmem_we    = dmem_req & mem_write_in;
   assign dmem_addr  = dmem_req ? {alu_res_in[31:2], 2'b00} : 32'h0;
   assign dmem_wdata = dmem_req ? st_data : 32'h0;
   assign dmem_be    = dmem_req ? be_int : 4'h0;
   assign dmem_err   = err_int & ~rst;
   assign stall      = stall_int & ~rst;

`ifdef MISALIGN_TRAP_EN
   assign misalign      = ~rst & (state == IDLE) & misaligned;
   assign misalign_addr = misalign ? alu_res_in : 32'h0;
`endif

   assign wb_en = ~rst & rf_en_in & (|rd_in) &
                  (((state == IDLE) & ~mem_op) |
                   ((state == DONE) & is_load_in & ~mem_write_in & ~aborted));
   assign wb_rd = rst ? 5'd0 : rd_in;

   always_comb begin
      wb_data = alu_res_in;
      if (is_jal_in | is_jalr_in)
         wb_data = pc_in + 32'd4;
      else if (is_csr_in)
         wb_data = csr_rdata_in;
      else if (is_load_in)
         wb_data = load_reg;
      if (rst)
         wb_data = 32'h0;
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage; expected writebacks are queued at stimulus time.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in, wdata_in, alu_res_in, csr_rdata_in, dmem_rdata;
   logic [4:0]  rd_in;
   logic        rf_en_in, mem_write_in, is_load_in, is_csr_in, is_jal_in, is_jalr_in;
   logic [2:0]  load_type_in;
   logic        load_unsigned_in, dmem_gnt, dmem_rvalid;
   logic        dmem_req, dmem_we, dmem_err, stall, wb_en;
   logic [31:0] dmem_addr, dmem_wdata, wb_data;
   logic [3:0]  dmem_be;
   logic [4:0]  wb_rd;
`ifdef MISALIGN_TRAP_EN
   logic        misalign;
   logic [31:0] misalign_addr;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;
   wb_t wb_q[$];
   wb_t mon_e;

   mem_wb_stage #(.REQ_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .rd_in(rd_in), .wdata_in(wdata_in),
      .alu_res_in(alu_res_in), .csr_rdata_in(csr_rdata_in), .rf_en_in(rf_en_in),
      .mem_write_in(mem_write_in), .is_load_in(is_load_in), .is_csr_in(is_csr_in),
      .is_jal_in(is_jal_in), .is_jalr_in(is_jalr_in), .load_type_in(load_type_in),
      .load_unsigned_in(load_unsigned_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .dmem_err(dmem_err), .stall(stall),
`ifdef MISALIGN_TRAP_EN
      .misalign(misalign), .misalign_addr(misalign_addr),
`endif
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

   // Writeback scoreboard: every observed write must match the oldest queued expectation.
   always @(negedge clk) begin
      if (wb_en === 1'b1) begin
         checks++;
         if (wb_q.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected: got rd=%0d data=%h, required no writeback", wb_rd, wb_data);
         end else begin
            mon_e = wb_q.pop_front();
            if (wb_rd !== mon_e.rd || wb_data !== mon_e.data) begin
               errors++;
               $display("FAIL wb_data: got rd=%0d data=%h, required rd=%0d data=%h",
                        wb_rd, wb_data, mon_e.rd, mon_e.data);
            end
         end
      end
   end

   task automatic set_nop();
      pc_in = 0; rd_in = 0; wdata_in = 0; alu_res_in = 0; csr_rdata_in = 0;
      rf_en_in = 0; mem_write_in = 0; is_load_in = 0; is_csr_in = 0;
      is_jal_in = 0; is_jalr_in = 0; load_type_in = 0; load_unsigned_in = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
      wb_t e;
      e.rd = rd;
      e.data = data;
      wb_q.push_back(e);
   endtask

   // Drives one access from IDLE through DONE and reports what the bus and stall showed.
   task automatic run_mem(input logic ld, input logic st, input logic [2:0] lt, input logic uns,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                          output int req_cyc, output logic [3:0] be, output logic [31:0] bw,
                          output logic [31:0] ba, output logic bwe, output logic wait_ok,
                          output logic done_stall, output int total);
      req_cyc = 0; total = 0; be = 0; bw = 0; ba = 0; bwe = 0; wait_ok = 1'b1;
      is_load_in = ld; mem_write_in = st; load_type_in = lt; load_unsigned_in = uns;
      alu_res_in = a; wdata_in = d; rd_in = rd; rf_en_in = 1'b1;
      for (int i = 0; i <= gnt_dly; i++) begin
         if (i == gnt_dly) dmem_gnt = 1'b1;
         @(negedge clk);
         if (dmem_req === 1'b1) begin
            if (req_cyc == 0) begin
               be = dmem_be; bw = dmem_wdata; ba = dmem_addr; bwe = dmem_we;
            end
            req_cyc++;
         end
         cyc();
         dmem_gnt = 1'b0;
         total++;
      end
      if (ld) begin
         for (int j = 0; j <= rv_dly; j++) begin
            if (j == rv_dly) begin
               dmem_rvalid = 1'b1;
               dmem_rdata = rdata;
            end
            @(negedge clk);
            if (stall !== 1'b1 || dmem_req !== 1'b0) wait_ok = 1'b0;
            cyc();
            dmem_rvalid = 1'b0;
            dmem_rdata = 0;
            total++;
         end
      end
      @(negedge clk);
      done_stall = stall;
      cyc();
      total++;
      set_nop();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_nop();
      dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
      is_jal_in = 1; rf_en_in = 1; rd_in = 1; pc_in = 32'h40;
      repeat (2) cyc();
      checks++;
      if ({dmem_req, dmem_we, dmem_err, stall, wb_en, wb_rd, wb_data, dmem_addr, dmem_wdata, dmem_be} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got req=%b stall=%b wb_en=%b wb_rd=%0d wb_data=%h, required all 0",
                  dmem_req, stall, wb_en, wb_rd, wb_data);
      end
      set_nop();
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_store();
      int rc, tot;
      logic [3:0] be;
      logic [31:0] bw, ba;
      logic we, wok, ds;
      run_mem(0, 1, 3'b010, 0, 32'h100, 32'hDEADBEEF, 5'd9, 2, 0, 0, rc, be, bw, ba, we, wok, ds, tot);
      checks++;
      if (rc !== 3 || tot !== 4) begin
         errors++;
         $display("FAIL sw_timing: got req_cycles=%0d total=%0d, required 3 and 4", rc, tot);
      end
      checks++;
      if (be !== 4'b1111 || bw !== 32'hDEADBEEF || ba !== 32'h100 || we !== 1'b1) begin
         errors++;
         $display("FAIL sw_bus: got be=%b wdata=%h addr=%h we=%b, required 1111 deadbeef 00000100 1", be, bw, ba, we);
      end
      checks++;
      if (ds !== 1'b0) begin
         errors++;
         $display("FAIL sw_done_stall: got %b, required 0", ds);
      end
      run_mem(0, 1, 3'b001, 0, 32'h102, 32'h1234ABCD, 5'd9, 0, 0, 0, rc, be, bw, ba, we, wok, ds, tot);
      checks++;
      if (be !== 4'b1100 || bw !== 32'hABCDABCD || ba !== 32'h100 || tot !== 2) begin
         errors++;
         $display("FAIL sh_bus: got be=%b wdata=%h addr=%h total=%0d, required 1100 abcdabcd 00000100 2", be, bw, ba, tot);
      end
      run_mem(0, 1, 3'b000, 0, 32'h101, 32'h000000AB, 5'd9, 1, 0, 0, rc, be, bw, ba, we, wok, ds, tot);
      checks++;
      if (be !== 4'b0010 || bw !== 32'hABABABAB || ba !== 32'h100) begin
         errors++;
         $display("FAIL sb_bus: got be=%b wdata=%h addr=%h, required 0010 abababab 00000100", be, bw, ba);
      end
   endtask

   task automatic test_load();
      int rc, tot;
      logic [3:0] be;
      logic [31:0] bw, ba;
      logic we, wok, ds;
      logic [2:0]  lt_t[5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
      logic        un_t[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] a_t[5]   = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h104};
      logic [31:0] rd_t[5]  = '{32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h12345678};
      logic [31:0] exp_t[5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h12345678};
      for (int k = 0; k < 5; k++) begin
         push_wb(5'd7, exp_t[k]);
         run_mem(1, 0, lt_t[k], un_t[k], a_t[k], 0, 5'd7, k % 2, (k == 0) ? 0 : 1, rd_t[k],
                 rc, be, bw, ba, we, wok, ds, tot);
         checks++;
         if (wb_q.size() != 0 || ds !== 1'b0 || wok !== 1'b1 || we !== 1'b0) begin
            errors++;
            $display("FAIL load_%0d: pending_wb=%0d done_stall=%b wait_ok=%b we=%b, required 0 0 1 0",
                     k, wb_q.size(), ds, wok, we);
            wb_q.delete();
         end
         if (k == 0) begin
            checks++;
            if (tot !== 3 || ba !== 32'h100) begin
               errors++;
               $display("FAIL load_latency: got total=%0d addr=%h, required 3 00000100", tot, ba);
            end
         end
      end
   endtask

   task automatic test_nonmem();
      logic [31:0] exp_d[4] = '{32'h44, 32'h1234, 32'hCAFE, 32'h204};
      pc_in = 32'h40; rd_in = 1; rf_en_in = 1; is_jal_in = 1;
      push_wb(5'd1, exp_d[0]);
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || wb_en !== 1'b1 || wb_data !== 32'h44) begin
         errors++;
         $display("FAIL jal: got stall=%b wb_en=%b wb_data=%h, required 0 1 00000044", stall, wb_en, wb_data);
      end
      cyc();
      set_nop();
      rf_en_in = 1; rd_in = 0; alu_res_in = 32'h55;
      @(negedge clk);
      checks++;
      if (wb_en !== 1'b0) begin
         errors++;
         $display("FAIL add_rd0: got wb_en=%b, required 0", wb_en);
      end
      cyc();
      rd_in = 3; alu_res_in = exp_d[1];
      push_wb(5'd3, exp_d[1]);
      cyc();
      set_nop();
      rf_en_in = 1; rd_in = 4; is_csr_in = 1; csr_rdata_in = exp_d[2]; alu_res_in = 32'h9;
      push_wb(5'd4, exp_d[2]);
      cyc();
      is_jalr_in = 1; pc_in = 32'h200; rd_in = 6;
      push_wb(5'd6, exp_d[3]);
      cyc();
      set_nop();
      checks++;
      if (wb_q.size() != 0) begin
         errors++;
         $display("FAIL nonmem_drain: got %0d pending writebacks, required 0", wb_q.size());
         wb_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      int rc, tot;
      logic [3:0] be;
      logic [31:0] bw, ba;
      logic we, wok, ds;
      push_wb(5'd10, 32'h0000BEEF);
      run_mem(1, 0, 3'b101, 1, 32'h200, 0, 5'd10, 0, 0, 32'h0000BEEF, rc, be, bw, ba, we, wok, ds, tot);
      run_mem(0, 1, 3'b010, 0, 32'h204, 32'h11223344, 5'd0, 0, 0, 0, rc, be, bw, ba, we, wok, ds, tot);
      checks++;
      if (ba !== 32'h204 || bw !== 32'h11223344 || tot !== 2 || wb_q.size() != 0) begin
         errors++;
         $display("FAIL back_to_back: got addr=%h wdata=%h total=%0d pending=%0d, required 00000204 11223344 2 0",
                  ba, bw, tot, wb_q.size());
         wb_q.delete();
      end
   endtask

   task automatic test_timeout();
      int reqs, err_at, errs;
      // Request phase: gnt never arrives.
      is_load_in = 1; load_type_in = 3'b010; alu_res_in = 32'h300; rd_in = 5; rf_en_in = 1;
      reqs = 0; err_at = -1; errs = 0;
      for (int i = 0; i < 20 && err_at < 0; i++) begin
         @(negedge clk);
         if (dmem_req === 1'b1) reqs++;
         if (dmem_err === 1'b1) begin err_at = i; errs++; end
         cyc();
      end
      @(negedge clk);
      if (dmem_err === 1'b1) errs++;
      checks++;
      if (reqs !== 4 || err_at !== 4 || errs !== 1 || stall !== 1'b0) begin
         errors++;
         $display("FAIL timeout_req: got reqs=%0d err_cycle=%0d err_pulses=%0d done_stall=%b, required 4 4 1 0",
                  reqs, err_at, errs, stall);
      end
      cyc();
      set_nop();
      cyc();
      // Data phase: granted, rvalid never arrives.
      is_load_in = 1; load_type_in = 3'b010; alu_res_in = 32'h300; rd_in = 5; rf_en_in = 1;
      err_at = -1;
      for (int i = 0; i < 20 && err_at < 0; i++) begin
         dmem_gnt = (i == 0);
         @(negedge clk);
         if (dmem_err === 1'b1) err_at = i;
         cyc();
         dmem_gnt = 1'b0;
      end
      checks++;
      if (err_at !== 5) begin
         errors++;
         $display("FAIL timeout_wait: got err_cycle=%0d, required 5", err_at);
      end
      cyc();
      set_nop();
      cyc();
   endtask

   task automatic test_rst_in_wait();
      is_load_in = 1; load_type_in = 3'b010; alu_res_in = 32'h400; rd_in = 8; rf_en_in = 1;
      dmem_gnt = 1'b1;
      cyc();
      dmem_gnt = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({dmem_req, dmem_err, stall, wb_en, wb_rd, wb_data} !== '0) begin
         errors++;
         $display("FAIL rst_in_wait: got req=%b stall=%b wb_en=%b wb_rd=%0d wb_data=%h, required all 0",
                  dmem_req, stall, wb_en, wb_rd, wb_data);
      end
      cyc();
      rst = 1'b0;
      set_nop();
      dmem_rvalid = 1'b1; dmem_rdata = 32'h5555AAAA;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || dmem_req !== 1'b0) begin
         errors++;
         $display("FAIL late_rvalid: got stall=%b req=%b, required 0 0", stall, dmem_req);
      end
      cyc();
      dmem_rvalid = 1'b0; dmem_rdata = 0;
      rf_en_in = 1; rd_in = 2; alu_res_in = 32'h77;
      push_wb(5'd2, 32'h77);
      @(negedge clk);
      checks++;
      if (wb_en !== 1'b1 || stall !== 1'b0) begin
         errors++;
         $display("FAIL post_rst_idle: got wb_en=%b stall=%b, required 1 0", wb_en, stall);
      end
      cyc();
      set_nop();
   endtask

`ifdef MISALIGN_TRAP_EN
   task automatic test_misalign();
      is_load_in = 1; load_type_in = 3'b010; alu_res_in = 32'h101; rd_in = 3; rf_en_in = 1;
      @(negedge clk);
      checks++;
      if (misalign !== 1'b1 || misalign_addr !== 32'h101 || dmem_req !== 1'b0 || stall !== 1'b0 || wb_en !== 1'b0) begin
         errors++;
         $display("FAIL misalign_lw: got mis=%b addr=%h req=%b stall=%b wb_en=%b, required 1 00000101 0 0 0",
                  misalign, misalign_addr, dmem_req, stall, wb_en);
      end
      cyc();
      is_load_in = 0; mem_write_in = 1; load_type_in = 3'b001; alu_res_in = 32'h102;
      @(negedge clk);
      checks++;
      if (misalign !== 1'b0 || dmem_req !== 1'b1) begin
         errors++;
         $display("FAIL misalign_sh_ok: got mis=%b req=%b, required 0 1", misalign, dmem_req);
      end
      dmem_gnt = 1'b1;
      cyc();
      dmem_gnt = 1'b0;
      cyc();
      set_nop();
   endtask
`endif

   initial begin
      test_reset();
      test_store();
      test_load();
      test_nonmem();
      test_back_to_back();
      test_timeout();
      test_rst_in_wait();
`ifdef MISALIGN_TRAP_EN
      test_misalign();
`endif
      repeat (2) cyc();
      checks++;
      if (wb_q.size() != 0) begin
         errors++;
         $display("FAIL final_drain: got %0d pending writebacks, required 0", wb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
